vga_fb_scanout: RTL and testbench

Scan-out stage driving the board VGA port (VGA_R/G/B, VGA_HS, VGA_VS) of single_cycle_cpu_board. Generates 640x480@60 timing from a clock-enable divider and fetches 12-bit RGB pixels from the CPU-written video RAM. The video RAM is 160x120 and each stored pixel covers a 4x4 block on screen. Outputs are registered and aligned to sync, plus a vblank flag and frame counter for software polling.

---
 rtl/vga_fb_scanout.sv | 184 ++++++++++++++++++
 tb/tb_vga_fb_scanout.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_scanout.sv
// VGA 640x480 scan-out: pixel-tick divider, raster counters, 2-stage fetch/output pipeline.
// Define VGA_TEST_PATTERN_EN to replace the framebuffer fetch with 8 vertical colour bars.
module vga_fb_scanout #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
  output logic [14:0] fb_addr,
  output logic        fb_ren,
  input  logic [11:0] fb_rdata,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        vblank,
  output logic [15:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  // Divider and raster counters
  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [15:0]   frame_q, frame_d;
  logic          tick, h_last, v_last;

  assign tick   = (div_q == DW'(CLK_DIV - 1));
  assign h_last = (h_q == HW'(H_TOTAL - 1));
  assign v_last = (v_q == VW'(V_TOTAL - 1));

  always_comb begin
    div_d   = tick ? '0 : div_q + 1'b1;
    h_d     = h_q;
    v_d     = v_q;
    frame_d = frame_q;
    if (tick) begin
      if (h_last) begin
        h_d = '0;
        if (v_last) begin
          v_d     = '0;
          frame_d = frame_q + 16'd1;
        end else begin
          v_d = v_q + 1'b1;
        end
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      frame_q <= '0;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      frame_q <= frame_d;
    end
  end

  // Raster decode for the pixel the counters currently hold
  logic        active, hs_n, vs_n, vb;
  logic [14:0] row, col, addr_d;

  always_comb begin
    active = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
    hs_n   = !((h_q >= HW'(H_ACTIVE + H_FP)) && (h_q < HW'(H_ACTIVE + H_FP + H_SYNC)));
    vs_n   = !((v_q >= VW'(V_ACTIVE + V_FP)) && (v_q < VW'(V_ACTIVE + V_FP + V_SYNC)));
    vb     = (v_q >= VW'(V_ACTIVE));
    row    = 15'(v_q >> 2);
    col    = 15'(h_q >> 2);
    // row*160 as two shifts
    addr_d = (row << 7) + (row << 5) + col;
  end

  // Stage 1: capture on the tick edge; stb/upd mark the two clks that follow it
  logic        stb_q, upd_q, ren_q, act_q, hs1_q, vs1_q, vb1_q;
  logic [14:0] addr_q;
  logic        ren_d;

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W = H_ACTIVE / 8;
  logic [2:0] bar_q;

  assign ren_d = 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bar_q <= '0;
    end else if (tick) begin
      bar_q <= 3'(h_q / HW'(BAR_W));
    end
  end
`else
  assign ren_d = active;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stb_q  <= 1'b0;
      upd_q  <= 1'b0;
      ren_q  <= 1'b0;
      act_q  <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      vb1_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      stb_q <= tick;
      upd_q <= stb_q;
      ren_q <= tick & ren_d;
      if (tick) begin
        act_q <= active;
        hs1_q <= hs_n;
        vs1_q <= vs_n;
        vb1_q <= vb;
        if (active) begin
          addr_q <= addr_d;
        end
      end
    end
  end

  // Stage 2: RAM data is valid in the clk after the read strobe
  logic [11:0] pix_d, pix_q;
  logic        hs2_q, vs2_q, vb2_q;

  always_comb begin
    pix_d = '0;
    if (act_q) begin
`ifdef VGA_TEST_PATTERN_EN
      // White bar first, black bar last
      logic [2:0] c;
      c     = 3'd7 - bar_q;
      pix_d = {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
`else
      pix_d = fb_rdata;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_q <= '0;
      hs2_q <= 1'b1;
      vs2_q <= 1'b1;
      vb2_q <= 1'b0;
    end else if (upd_q) begin
      pix_q <= pix_d;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
      vb2_q <= vb1_q;
    end
  end

  assign fb_addr   = addr_q;
  assign fb_ren    = ren_q;
  assign VGA_R     = pix_q[11:8];
  assign VGA_G     = pix_q[7:4];
  assign VGA_B     = pix_q[3:0];
  assign VGA_HS    = hs2_q;
  assign VGA_VS    = vs2_q;
  assign vblank    = vb2_q;
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Bench for vga_fb_scanout on a reduced raster; outputs are checked every clk against a
// closed-form model of the scan position derived from the clk count since reset.
module tb_vga_fb_scanout;

  localparam int unsigned D   = 3;
  localparam int unsigned HA  = 32;
  localparam int unsigned HFP = 4;
  localparam int unsigned HSY = 6;
  localparam int unsigned HBP = 6;
  localparam int unsigned VA  = 16;
  localparam int unsigned VFP = 2;
  localparam int unsigned VSY = 2;
  localparam int unsigned VBP = 3;
  localparam int unsigned HT  = HA + HFP + HSY + HBP;
  localparam int unsigned VT  = VA + VFP + VSY + VBP;
  localparam int unsigned F   = HT * VT;
  localparam logic [14:0] MAX_ADDR = 15'(((VA - 1) / 4) * 160 + (HA - 1) / 4);
  localparam logic [46:0] RST_VEC  = {1'b0, 15'd0, 12'd0, 1'b1, 1'b1, 1'b0, 16'd0};
`ifdef VGA_TEST_PATTERN_EN
  localparam bit TP = 1'b1;
`else
  localparam bit TP = 1'b0;
`endif

  logic        clk, rst, fb_ren, hs, vs, vblank;
  logic [14:0] fb_addr;
  logic [11:0] fb_rdata;
  logic [3:0]  r, g, b;
  logic [15:0] frame_cnt;

  logic [11:0] mem [0:19199];
  int unsigned ecount;
  int          checks, errors;
  logic [14:0] max_addr;

  vga_fb_scanout #(
    .CLK_DIV (D),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .fb_addr  (fb_addr),
    .fb_ren   (fb_ren),
    .fb_rdata (fb_rdata),
    .VGA_R    (r),
    .VGA_G    (g),
    .VGA_B    (b),
    .VGA_HS   (hs),
    .VGA_VS   (vs),
    .vblank   (vblank),
    .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges since reset release
  always @(posedge clk or negedge rst) begin
    if (!rst) ecount <= 0;
    else      ecount <= ecount + 1;
  end

  // Synchronous RAM; garbage when not strobed
  always @(posedge clk) begin
    if (fb_ren) fb_rdata <= mem[fb_addr];
    else        fb_rdata <= 12'($urandom);
  end

  function automatic logic [14:0] pix_addr(int unsigned h, int unsigned v);
    return 15'((v / 4) * 160 + h / 4);
  endfunction

  function automatic logic [11:0] bar_rgb(int unsigned h);
    int unsigned c;
    c = 7 - h / (HA / 8);
    return {((c >> 2) & 1) != 0 ? 4'hF : 4'h0,
            ((c >> 1) & 1) != 0 ? 4'hF : 4'h0,
            (c & 1) != 0 ? 4'hF : 4'h0};
  endfunction

  // Tick k happens at edge k*D and captures scan pixel k-1; that pixel shows 2 clk later.
  function automatic logic [46:0] model(int unsigned e);
    int unsigned kl, k2, q, h, v, lh, lv;
    logic ren, hsx, vsx, vbx;
    logic [14:0] addr;
    logic [11:0] rgb;
    ren = 1'b0; addr = '0; rgb = '0; hsx = 1'b1; vsx = 1'b1; vbx = 1'b0;
    kl = e / D;
    if (kl > 0) begin
      q = (kl - 1) % F; h = q % HT; v = q / HT;
      if (v < VA && h < HA) begin
        lh = h; lv = v;
        ren = !TP && (e % D == 0);
      end else if (v < VA) begin
        lh = HA - 1; lv = v;
      end else begin
        lh = HA - 1; lv = VA - 1;
      end
      addr = pix_addr(lh, lv);
    end
    k2 = (e >= 2) ? (e - 2) / D : 0;
    if (k2 > 0) begin
      q = (k2 - 1) % F; h = q % HT; v = q / HT;
      hsx = !(h >= HA + HFP && h < HA + HFP + HSY);
      vsx = !(v >= VA + VFP && v < VA + VFP + VSY);
      vbx = (v >= VA);
      if (v < VA && h < HA) rgb = TP ? bar_rgb(h) : mem[pix_addr(h, v)];
    end
    return {ren, addr, rgb, hsx, vsx, vbx, 16'(kl / F)};
  endfunction

  function automatic logic [46:0] outs();
    return {fb_ren, fb_addr, r, g, b, hs, vs, vblank, frame_cnt};
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s e=%0d got=%h exp=%h", name, ecount, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    check("scan", 64'(outs()), 64'(model(ecount)));
    if (fb_addr > max_addr) max_addr = fb_addr;
  endtask

  task automatic wait_e(int unsigned t);
    int n = 0;
    while (ecount < t && n < 20000) begin
      step();
      n++;
    end
    check("wait_bound", 64'(ecount), 64'(t));
  endtask

  typedef struct {
    int unsigned h, v;
    logic hs, vs, vb, act;
  } vec_t;
  vec_t tbl [12];

  initial begin
    checks = 0; errors = 0; max_addr = '0;
    rst = 1'b0;
    tbl[0]  = '{0, 0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{31, 0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{35, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{36, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{41, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{42, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{47, 15, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{0, 16, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{5, 18, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{36, 19, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{0, 20, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{47, 22, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 19200; i++) mem[i] = 12'($urandom);

    #100;
    check("reset_outs", 64'(outs()), 64'(RST_VEC));
    @(posedge clk); #2 rst = 1'b1;

    for (int i = 1; i <= int'(D); i++) begin
      step();
      check("first_ren", 64'(fb_ren), 64'((ecount == D) && !TP));
      if (ecount == D) check("first_addr", 64'(fb_addr), 64'd0);
    end

    for (int i = 0; i < 12; i++) begin
      logic [11:0] exp_rgb;
      wait_e((tbl[i].v * HT + tbl[i].h + 1) * D + 2);
      exp_rgb = !tbl[i].act ? 12'h000 :
                TP ? bar_rgb(tbl[i].h) : mem[pix_addr(tbl[i].h, tbl[i].v)];
      check("tbl_sync", 64'({hs, vs, vblank}), 64'({tbl[i].hs, tbl[i].vs, tbl[i].vb}));
      check("tbl_rgb", 64'({r, g, b}), 64'(exp_rgb));
    end

    wait_e(2 * F * D);
    check("frame_cnt", 64'(frame_cnt), 64'd2);
    check("max_addr", 64'(max_addr), 64'(MAX_ADDR));

    // Asynchronous reset mid-frame, then the single-block addressing pattern
    repeat ($urandom_range(200, 2500)) step();
    @(posedge clk); #2 rst = 1'b0;
    #1 check("async_reset", 64'(outs()), 64'(RST_VEC));
    for (int i = 0; i < 19200; i++) mem[i] = 12'h000;
    mem[161] = 12'hF0F;
    repeat (3) step();
    @(posedge clk); #2 rst = 1'b1;
    wait_e((5 * HT + 5 + 1) * D + 2);
    check("pix_5_5", 64'({r, g, b}), 64'(TP ? bar_rgb(5) : 12'hF0F));
    wait_e((5 * HT + 8 + 1) * D + 2);
    check("pix_8_5", 64'({r, g, b}), 64'(TP ? bar_rgb(8) : 12'h000));
    wait_e(F * D + 4);

    // All-white RAM: blanking must still force black
    @(posedge clk); #2 rst = 1'b0;
    for (int i = 0; i < 19200; i++) mem[i] = 12'hFFF;
    max_addr = '0;
    repeat (2) step();
    @(posedge clk); #2 rst = 1'b1;
    wait_e(F * D + 10);
    check("max_addr_2", 64'(max_addr), 64'(MAX_ADDR));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
